fetch_pc_unit: RTL and testbench

Fetch-stage next-PC generator that sits directly downstream of the 2-bit branch predictor and consumes its `prediction` bit. It holds the program counter, looks up a direct-mapped branch target buffer (BTB) to find predicted-taken targets, and redirects fetch when the execute stage resolves a mispredicted branch. It also drives the resolved-outcome feedback back to the predictor and keeps saturating branch and mispredict statistics.

---
 rtl/fetch_pc_unit_if.sv | 35 +++
 rtl/fetch_pc_unit.sv | 114 +++++++++++
 tb/tb_fetch_pc_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bundle between the next-PC unit and its neighbours: the predictor,
// the execute-stage branch resolution, the fetch stall, and the statistics outputs.
interface fetch_pc_unit_if;
    logic        if_stall;
    logic        bp_prediction;
    logic        ex_branch_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;

    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        flush;
    logic        bp_update;
    logic        bp_outcome;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    modport master (
        output if_stall, bp_prediction, ex_branch_valid, ex_pc, ex_taken,
               ex_target, ex_pred_taken, ex_pred_target,
        input  if_pc, if_pred_taken, if_pred_target, flush, bp_update,
               bp_outcome, branch_count, mispredict_count
    );

    modport slave (
        input  if_stall, bp_prediction, ex_branch_valid, ex_pc, ex_taken,
               ex_target, ex_pred_taken, ex_pred_target,
        output if_pc, if_pred_taken, if_pred_target, flush, bp_update,
               bp_outcome, branch_count, mispredict_count
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Next-PC generator: holds the fetch PC, predicts taken branches through a
// direct-mapped BTB gated by the predictor bit, and redirects on EX mispredicts.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    fetch_pc_unit_if.slave  bus
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [31:0]            r_pc;
    logic [BTB_ENTRIES-1:0] r_btb_valid;
    logic [TAG_W-1:0]       r_btb_tag    [BTB_ENTRIES];
    logic [31:0]            r_btb_target [BTB_ENTRIES];
    logic [15:0]            r_branch_count;
    logic [15:0]            r_mispredict_count;

    logic [IDX_W-1:0]       w_lkp_idx;
    logic [TAG_W-1:0]       w_lkp_tag;
    logic                   w_lkp_hit;
    logic                   w_pred_taken;
    logic [31:0]            w_pred_target;
    logic                   w_mispredict;
    logic [31:0]            w_redirect_pc;
    logic [31:0]            w_pc_next;
    logic                   w_wr_en;
    logic [IDX_W-1:0]       w_wr_idx;
    logic [TAG_W-1:0]       w_wr_tag;
    logic [BTB_ENTRIES-1:0] w_wr_sel;

    // Lookup on the current fetch PC; pc[1:0] never participates
    assign w_lkp_idx     = r_pc[IDX_W+1:2];
    assign w_lkp_tag     = r_pc[31:IDX_W+2];
    assign w_lkp_hit     = r_btb_valid[w_lkp_idx] && (r_btb_tag[w_lkp_idx] == w_lkp_tag);
    assign w_pred_taken  = w_lkp_hit && bus.bp_prediction;
    assign w_pred_target = w_lkp_hit ? r_btb_target[w_lkp_idx] : 32'h0000_0000;

    assign w_mispredict  = bus.ex_branch_valid &&
                           ((bus.ex_taken != bus.ex_pred_taken) ||
                            (bus.ex_taken && (bus.ex_pred_target != bus.ex_target)));
    assign w_redirect_pc = bus.ex_taken ? bus.ex_target : (bus.ex_pc + 32'd4);

    always_comb begin
        w_pc_next = r_pc + 32'd4;
        if (w_mispredict) begin
            w_pc_next = w_redirect_pc;
        end else if (bus.if_stall) begin
            w_pc_next = r_pc;
        end else if (w_pred_taken) begin
            w_pc_next = w_pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Only taken resolutions allocate; not-taken ones leave the BTB untouched
    assign w_wr_en  = bus.ex_branch_valid && bus.ex_taken;
    assign w_wr_idx = bus.ex_pc[IDX_W+1:2];
    assign w_wr_tag = bus.ex_pc[31:IDX_W+2];

    generate
        for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_wr_sel
            assign w_wr_sel[gi] = w_wr_en && (w_wr_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btb_valid <= '0;
        end else begin
            r_btb_valid <= r_btb_valid | w_wr_sel;
        end
    end

    // Tag/target storage has no reset so it can map onto distributed RAM
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_btb_tag[w_wr_idx]    <= w_wr_tag;
            r_btb_target[w_wr_idx] <= bus.ex_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_count     <= 16'h0000;
            r_mispredict_count <= 16'h0000;
        end else begin
            if (bus.ex_branch_valid && (r_branch_count != 16'hFFFF)) begin
                r_branch_count <= r_branch_count + 16'd1;
            end
            if (w_mispredict && (r_mispredict_count != 16'hFFFF)) begin
                r_mispredict_count <= r_mispredict_count + 16'd1;
            end
        end
    end

    assign bus.if_pc            = r_pc;
    assign bus.if_pred_taken    = w_pred_taken;
    assign bus.if_pred_target   = w_pred_target;
    assign bus.flush            = w_mispredict;
    assign bus.bp_update        = bus.ex_branch_valid;
    assign bus.bp_outcome       = bus.ex_branch_valid & bus.ex_taken;
    assign bus.branch_count     = r_branch_count;
    assign bus.mispredict_count = r_mispredict_count;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a per-cycle vector table followed by
// reset-override, PC wrap and counter saturation sequences.
module tb_fetch_pc_unit;
    logic clk = 1'b0;
    logic rst;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(
        .RESET_PC   (32'h0000_0100),
        .BTB_ENTRIES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        bpp;
        logic        exv;
        logic [31:0] expc;
        logic        ext;
        logic [31:0] extg;
        logic        expt;
        logic [31:0] exptg;
        logic [31:0] e_pc;
        logic        e_pt;
        logic [31:0] e_ptg;
        logic        e_fl;
        logic        e_out;
        logic [15:0] e_bc;
        logic [15:0] e_mc;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(
        input logic stall, input logic bpp, input logic exv, input logic [31:0] expc,
        input logic ext, input logic [31:0] extg, input logic expt, input logic [31:0] exptg,
        input logic [31:0] e_pc, input logic e_pt, input logic [31:0] e_ptg,
        input logic e_fl, input logic e_out, input logic [15:0] e_bc, input logic [15:0] e_mc);
        vec_t v;
        v.stall = stall; v.bpp = bpp; v.exv = exv; v.expc = expc;
        v.ext = ext; v.extg = extg; v.expt = expt; v.exptg = exptg;
        v.e_pc = e_pc; v.e_pt = e_pt; v.e_ptg = e_ptg;
        v.e_fl = e_fl; v.e_out = e_out; v.e_bc = e_bc; v.e_mc = e_mc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic bpp, input logic exv,
                         input logic [31:0] expc, input logic ext, input logic [31:0] extg,
                         input logic expt, input logic [31:0] exptg);
        bus.if_stall        = stall;
        bus.bp_prediction   = bpp;
        bus.ex_branch_valid = exv;
        bus.ex_pc           = expc;
        bus.ex_taken        = ext;
        bus.ex_target       = extg;
        bus.ex_pred_taken   = expt;
        bus.ex_pred_target  = exptg;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stall bpp exv ex_pc ext ex_tgt expt ex_ptg | pc pt ptg flush out bc mc
        vecs[0]  = mk(0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h100,0,32'h0,  0,0,0,0);
        vecs[1]  = mk(0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h104,0,32'h0,  0,0,0,0);
        vecs[2]  = mk(0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h108,0,32'h0,  0,0,0,0);
        vecs[3]  = mk(0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h10C,0,32'h0,  0,0,0,0);
        // train 0x108 -> 0x200 via a not-predicted taken branch
        vecs[4]  = mk(0,0,1,32'h108,1,32'h200,0,32'h0,   32'h110,0,32'h0,  1,1,0,0);
        vecs[5]  = mk(0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h200,0,32'h0,  0,0,1,1);
        vecs[6]  = mk(0,0,1,32'h500,1,32'h108,0,32'h0,   32'h204,0,32'h0,  1,1,1,1);
        vecs[7]  = mk(0,1,0,32'h0,  0,32'h0,  0,32'h0,   32'h108,1,32'h200,0,0,2,2);
        vecs[8]  = mk(0,0,1,32'h600,1,32'h108,0,32'h0,   32'h200,0,32'h0,  1,1,2,2);
        vecs[9]  = mk(0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h108,0,32'h200,0,0,3,3);
        // correctly predicted taken branch: no flush
        vecs[10] = mk(0,0,1,32'h108,1,32'h200,1,32'h200, 32'h10C,0,32'h0,  0,1,3,3);
        // predicted taken, actually not taken
        vecs[11] = mk(0,0,1,32'h108,0,32'h999,1,32'h200, 32'h110,0,32'h0,  1,0,4,3);
        vecs[12] = mk(0,0,1,32'h700,1,32'h108,0,32'h0,   32'h10C,0,32'h0,  1,1,5,4);
        // wrong target; lookup in same cycle still sees the old 0x200
        vecs[13] = mk(0,1,1,32'h108,1,32'h300,1,32'h200, 32'h108,1,32'h200,1,1,6,5);
        vecs[14] = mk(0,0,1,32'h700,1,32'h108,0,32'h0,   32'h300,0,32'h0,  1,1,7,6);
        // three stall cycles; mispredict in the last one evicts 0x108 with alias 0x148
        vecs[15] = mk(1,1,0,32'h0,  0,32'h0,  0,32'h0,   32'h108,1,32'h300,0,0,8,7);
        vecs[16] = mk(1,1,0,32'h0,  0,32'h0,  0,32'h0,   32'h108,1,32'h300,0,0,8,7);
        vecs[17] = mk(1,1,1,32'h148,1,32'h400,0,32'h0,   32'h108,1,32'h300,1,1,8,7);
        vecs[18] = mk(0,1,1,32'h800,1,32'h108,0,32'h0,   32'h400,0,32'h0,  1,1,9,8);
        vecs[19] = mk(0,1,0,32'h0,  0,32'h0,  0,32'h0,   32'h108,0,32'h0,  0,0,10,9);
        vecs[20] = mk(0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h10C,0,32'h0,  0,0,10,9);

        rst = 1'b1;
        drive(0,0,0,32'h0,0,32'h0,0,32'h0);
        step();
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].stall, vecs[i].bpp, vecs[i].exv, vecs[i].expc,
                  vecs[i].ext, vecs[i].extg, vecs[i].expt, vecs[i].exptg);
            @(negedge clk);
            $display("[TB] row %0d pc=%h pt=%0b ptg=%h flush=%0b bc=%0d mc=%0d", i,
                     bus.if_pc, bus.if_pred_taken, bus.if_pred_target, bus.flush,
                     bus.branch_count, bus.mispredict_count);
            check($sformatf("row%0d if_pc", i),            bus.if_pc,            vecs[i].e_pc);
            check($sformatf("row%0d if_pred_taken", i),    32'(bus.if_pred_taken),  32'(vecs[i].e_pt));
            check($sformatf("row%0d if_pred_target", i),   bus.if_pred_target,   vecs[i].e_ptg);
            check($sformatf("row%0d flush", i),            32'(bus.flush),       32'(vecs[i].e_fl));
            check($sformatf("row%0d bp_update", i),        32'(bus.bp_update),   32'(vecs[i].exv));
            check($sformatf("row%0d bp_outcome", i),       32'(bus.bp_outcome),  32'(vecs[i].e_out));
            check($sformatf("row%0d branch_count", i),     32'(bus.branch_count),     32'(vecs[i].e_bc));
            check($sformatf("row%0d mispredict_count", i), 32'(bus.mispredict_count), 32'(vecs[i].e_mc));
            step();
        end

        // Reset overrides a same-cycle mispredict and BTB write
        rst = 1'b1;
        drive(0,1,1,32'h104,1,32'h500,0,32'h0);
        @(negedge clk);
        check("rst flush comb", 32'(bus.flush), 32'd1);
        check("rst bp_outcome comb", 32'(bus.bp_outcome), 32'd1);
        step();
        rst = 1'b0;
        drive(0,1,0,32'h0,0,32'h0,0,32'h0);
        @(negedge clk);
        $display("[TB] after mid-run reset pc=%h bc=%0d mc=%0d", bus.if_pc, bus.branch_count, bus.mispredict_count);
        check("rst if_pc", bus.if_pc, 32'h100);
        check("rst branch_count", 32'(bus.branch_count), 32'd0);
        check("rst mispredict_count", 32'(bus.mispredict_count), 32'd0);
        check("rst pred_taken@0x100", 32'(bus.if_pred_taken), 32'd0);
        step();
        @(negedge clk);
        check("rst no write if_pc", bus.if_pc, 32'h104);
        check("rst no write pred_taken", 32'(bus.if_pred_taken), 32'd0);
        check("rst no write pred_target", bus.if_pred_target, 32'h0);

        // PC wrap at the top of the address space
        step();
        drive(0,0,1,32'h10,1,32'hFFFF_FFFC,0,32'h0);
        step();
        drive(0,0,0,32'h0,0,32'h0,0,32'h0);
        @(negedge clk);
        $display("[TB] wrap redirect pc=%h", bus.if_pc);
        check("wrap redirect pc", bus.if_pc, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        $display("[TB] wrap sequential pc=%h", bus.if_pc);
        check("wrap sequential pc", bus.if_pc, 32'h0);
        drive(0,0,1,32'hFFFF_FFFC,0,32'h0,1,32'h0);
        step();
        drive(0,0,0,32'h0,0,32'h0,0,32'h0);
        @(negedge clk);
        check("wrap not-taken redirect pc", bus.if_pc, 32'h0);

        // Counter saturation
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0,0,1,32'h0,0,32'h0,1,32'h0);
        repeat (65534) step();
        @(negedge clk);
        $display("[TB] sat pre bc=%h mc=%h", bus.branch_count, bus.mispredict_count);
        check("sat pre branch_count", 32'(bus.branch_count), 32'h0000_FFFE);
        check("sat pre mispredict_count", 32'(bus.mispredict_count), 32'h0000_FFFE);
        repeat (6) step();
        drive(0,0,0,32'h0,0,32'h0,0,32'h0);
        step();
        @(negedge clk);
        $display("[TB] sat post bc=%h mc=%h", bus.branch_count, bus.mispredict_count);
        check("sat branch_count", 32'(bus.branch_count), 32'h0000_FFFF);
        check("sat mispredict_count", 32'(bus.mispredict_count), 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
